// File: rtl/fifo_read_ctrl.sv
// Read-domain half of a dual-clock FIFO.
// Owns the binary/Gray read pointer, derives empty and level from the
// synchronized write pointer, fetches words from the dual-port memory and
// presents them on a valid/ready stream through a 2-entry output buffer.
module fifo_read_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray_sync,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   rd_level
);

    localparam int PW = ADDR_WIDTH + 1;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0]         rd_ptr_bin_q, rd_ptr_bin_d;
    logic [PW-1:0]         rd_ptr_gray_q, rd_ptr_gray_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [1:0]            buf_count_q, buf_count_d;
    logic                  inflight_q, inflight_d;

    logic [PW-1:0]         wr_bin_sync;
    logic                  pop;
    logic [1:0]            occ;
    logic                  fetch;

    // Pointer comparison, stream outputs and the fetch decision.
    // occ counts buffered words plus the word on its way from memory; a new
    // fetch is only allowed if, after this cycle's pop, there is room for it.
    always_comb begin
        wr_bin_sync = gray2bin(wr_ptr_gray_sync);
        empty       = (rd_ptr_gray_q == wr_ptr_gray_sync);
        rd_level    = wr_bin_sync - rd_ptr_bin_q;
        out_valid   = (buf_count_q != 2'd0);
        out_data    = buf0_q;
        rd_ptr_gray = rd_ptr_gray_q;
        mem_rd_addr = rd_ptr_bin_q[ADDR_WIDTH-1:0];
        pop         = out_valid && out_ready;
        occ         = buf_count_q + {1'b0, inflight_q};
        fetch       = !rst && !empty && ((occ - {1'b0, pop}) < 2'd2);
        mem_rd_en   = fetch;
    end

    // Next-state: pointer advance on fetch, in-flight tracking, and the
    // 2-entry buffer where buf0 is always the head shown on out_data.
    always_comb begin
        rd_ptr_bin_d  = rd_ptr_bin_q;
        rd_ptr_gray_d = rd_ptr_gray_q;
        buf0_d        = buf0_q;
        buf1_d        = buf1_q;
        buf_count_d   = buf_count_q;
        inflight_d    = fetch;

        if (fetch) begin
            rd_ptr_bin_d  = rd_ptr_bin_q + PW'(1);
            rd_ptr_gray_d = bin2gray(rd_ptr_bin_q + PW'(1));
        end

        // inflight_q means mem_rd_data carries the word fetched last cycle.
        unique case ({inflight_q, pop})
            2'b10: begin
                if (buf_count_q == 2'd0) begin
                    buf0_d = mem_rd_data;
                end else begin
                    buf1_d = mem_rd_data;
                end
                buf_count_d = buf_count_q + 2'd1;
            end
            2'b01: begin
                buf0_d      = buf1_q;
                buf_count_d = buf_count_q - 2'd1;
            end
            2'b11: begin
                if (buf_count_q == 2'd1) begin
                    buf0_d = mem_rd_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = mem_rd_data;
                end
            end
            default: begin
            end
        endcase
    end

    // State registers; reset discards buffered and in-flight words.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            rd_ptr_bin_q  <= '0;
            rd_ptr_gray_q <= '0;
            buf0_q        <= '0;
            buf1_q        <= '0;
            buf_count_q   <= 2'd0;
            inflight_q    <= 1'b0;
        end else begin
            rd_ptr_bin_q  <= rd_ptr_bin_d;
            rd_ptr_gray_q <= rd_ptr_gray_d;
            buf0_q        <= buf0_d;
            buf1_q        <= buf1_d;
            buf_count_q   <= buf_count_d;
            inflight_q    <= inflight_d;
        end
    end

endmodule
